// File: rtl/an_code_pkg.sv
`default_nettype none
// ============================================================================
// Module      : an_code_pkg
// Description : Constants, FSM state type and syndrome lookup for the AN-code
//               (A = 19) single-error decoder.
// Revision    : 1.0  initial release
// ============================================================================
package an_code_pkg;

    localparam int A       = 19;
    localparam int AN_W    = 9;
    localparam int N_W     = 4;
    localparam int C_SYN_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYND = 2'd1,
        FIX  = 2'd2,
        RESP = 2'd3
    } state_t;

    // pos = 1 marks a positive-error syndrome (2^i mod A)
    typedef struct packed {
        logic       hit;
        logic       pos;
        logic [3:0] bit_idx;
    } syn_entry_t;

    localparam logic [5:0] C_SYN_LUT [0:31] = '{
        6'h00, 6'h30, 6'h31, 6'h24, 6'h32, 6'h27, 6'h25, 6'h36,
        6'h33, 6'h38, 6'h28, 6'h23, 6'h26, 6'h35, 6'h37, 6'h22,
        6'h34, 6'h21, 6'h20, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
        6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00
    };

endpackage
`default_nettype wire

// File: rtl/an_decode_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : an_decode_arbiter_if
// Description : Request/response bundle between requesters, consumer and the
//               shared AN-code decoder.
// Revision    : 1.0  initial release
// ============================================================================
interface an_decode_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int AN_W    = 9,
    parameter int N_W     = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*AN_W-1:0] req_an;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [N_W-1:0]          rsp_n;
    logic                    rsp_corr;
    logic                    rsp_uncorr;

    modport master (
        output req_valid, req_an, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_n, rsp_corr, rsp_uncorr
    );

    modport slave (
        input  req_valid, req_an, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_n, rsp_corr, rsp_uncorr
    );
endinterface
`default_nettype wire

// File: rtl/an_syndrome_corrector.sv
`default_nettype none
// ============================================================================
// Module      : an_syndrome_corrector
// Description : Combinational single-bit correction and divide-by-A for one
//               codeword given its syndrome.
// Revision    : 1.0  initial release
// ============================================================================
module an_syndrome_corrector
    import an_code_pkg::*;
(
    input  logic [AN_W-1:0]    i_an_e,
    input  logic [C_SYN_W-1:0] i_syn,
    output logic [AN_W-1:0]    o_an_c,
    output logic [N_W-1:0]     o_n,
    output logic               o_corr,
    output logic               o_uncorr
);
    syn_entry_t      w_ent;
    logic [AN_W-1:0] w_flip;
    logic [AN_W-1:0] w_quot;
    logic            w_bit;

    always_comb begin
        w_ent  = syn_entry_t'(C_SYN_LUT[i_syn]);
        w_flip = '0;
        if (w_ent.hit) begin
            w_flip = AN_W'(1) << w_ent.bit_idx;
        end
        w_bit    = |(i_an_e & w_flip);
        o_an_c   = i_an_e ^ w_flip;
        w_quot   = o_an_c / AN_W'(A);
        o_n      = w_quot[N_W-1:0];
        o_corr   = (i_syn != '0);
        // a positive error must have hit a 1, a negative error a 0
        o_uncorr = (o_corr && !w_ent.hit)
                || (w_ent.hit && (w_bit != w_ent.pos))
                || (w_quot > AN_W'((2 ** N_W) - 1));
    end

endmodule
`default_nettype wire

// File: rtl/an_decode_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : an_decode_arbiter
// Description : Round-robin arbiter and 4-state sequencer sharing one AN-code
//               decoder. Optional macro ANDEC_STATS_EN adds corr/uncorr counters.
// Revision    : 1.0  initial release
// ============================================================================
module an_decode_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int A       = 19,
    parameter int AN_W    = 9,
    parameter int N_W     = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    an_decode_arbiter_if.slave   bus,
    output logic                 busy
`ifdef ANDEC_STATS_EN
    ,
    output logic [15:0]          corr_cnt,
    output logic [15:0]          uncorr_cnt
`endif
);
    import an_code_pkg::*;

    state_t                 r_state;
    state_t                 w_next;
    logic [ID_W-1:0]        r_ptr;
    logic [ID_W-1:0]        r_id;
    logic [AN_W-1:0]        r_an_e;
    logic [C_SYN_W-1:0]     r_syn;
    logic [N_W-1:0]         r_rsp_n;
    logic                   r_rsp_corr;
    logic                   r_rsp_uncorr;

    logic                   w_found;
    logic [ID_W-1:0]        w_gnt_id;
    logic [ID_W-1:0]        w_idx;
    logic [ID_W-1:0]        w_ptr_nxt;
    logic [NUM_REQ-1:0]     w_req_ready;
    logic [AN_W-1:0]        w_sel_an;
    logic                   w_accept;
    logic [AN_W-1:0]        w_an_c;
    logic [N_W-1:0]         w_n;
    logic                   w_corr;
    logic                   w_uncorr;

    // first valid requester at or after the pointer, searching circularly
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_gnt_id = w_idx;
            end
        end
    end

    always_comb begin
        w_sel_an = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_gnt_id == ID_W'(k)) begin
                w_sel_an = bus.req_an[k*AN_W +: AN_W];
            end
        end
    end

    assign w_ptr_nxt = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + ID_W'(1);
    assign w_accept  = (r_state == IDLE) && w_found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_req_ready = '0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_found) begin
                    w_req_ready = NUM_REQ'(1) << w_gnt_id;
                    w_next      = SYND;
                end
            end
            SYND:    w_next = FIX;
            FIX:     w_next = RESP;
            RESP:    if (bus.rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    an_syndrome_corrector u_corrector (
        .i_an_e   (r_an_e),
        .i_syn    (r_syn),
        .o_an_c   (w_an_c),
        .o_n      (w_n),
        .o_corr   (w_corr),
        .o_uncorr (w_uncorr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr        <= '0;
            r_id         <= '0;
            r_an_e       <= '0;
            r_syn        <= '0;
            r_rsp_n      <= '0;
            r_rsp_corr   <= 1'b0;
            r_rsp_uncorr <= 1'b0;
        end else begin
            if (w_accept) begin
                r_an_e <= w_sel_an;
                r_id   <= w_gnt_id;
                r_ptr  <= w_ptr_nxt;
            end
            if (r_state == SYND) begin
                r_syn <= C_SYN_W'(r_an_e % AN_W'(A));
            end
            if (r_state == FIX) begin
                r_rsp_n      <= w_n;
                r_rsp_corr   <= w_corr;
                r_rsp_uncorr <= w_uncorr;
            end
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.rsp_valid  = (r_state == RESP);
    assign bus.rsp_id     = r_id;
    assign bus.rsp_n      = r_rsp_n;
    assign bus.rsp_corr   = r_rsp_corr;
    assign bus.rsp_uncorr = r_rsp_uncorr;

`ifdef ANDEC_STATS_EN
    logic [15:0] r_corr_cnt;
    logic [15:0] r_uncorr_cnt;
    logic        w_rsp_hs;

    assign w_rsp_hs = (r_state == RESP) && bus.rsp_ready;

    // saturating event counters, updated on each response handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else begin
            if (w_rsp_hs && r_rsp_corr && (r_corr_cnt != 16'hFFFF)) begin
                r_corr_cnt <= r_corr_cnt + 16'd1;
            end
            if (w_rsp_hs && r_rsp_uncorr && (r_uncorr_cnt != 16'hFFFF)) begin
                r_uncorr_cnt <= r_uncorr_cnt + 16'd1;
            end
        end
    end

    assign corr_cnt   = r_corr_cnt;
    assign uncorr_cnt = r_uncorr_cnt;
`endif

    // w_an_c is kept for visibility of the corrected codeword
    logic w_unused;
    assign w_unused = ^w_an_c;

endmodule
`default_nettype wire
